note_sequencer: RTL and testbench
=================================

NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter NOTE_W, default 4, bit width of a note code; 0 means rest, all-ones means end marker.
REQ-002 SHALL have parameter SONG_CNT, default 4, number of songs held in the internal ROM.
REQ-003 SHALL have parameter SONG_LEN, default 32, number of ROM entries per song.
REQ-004 SHALL have parameter TICKS_PER_BEAT, default 25_000_000, number of clk cycles per beat.
REQ-005 SHALL have parameter GAP_TICKS, default 2_000_000, number of silent cycles per note when the gap feature is compiled in.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-008 SHALL have port song_select, input, clog2(SONG_CNT) bits, song index.
REQ-009 SHALL have ports start, pause and stop, inputs, 1 bit each, level-sampled commands.
REQ-010 SHALL have port loop_en, input, 1 bit, restarts the song at its end when high.
REQ-011 SHALL have port current_note, output, NOTE_W bits, note code to the buzzer driver.
REQ-012 SHALL have port note_index, output, clog2(SONG_LEN) bits, index of the current entry.
REQ-013 SHALL have port playing, output, 1 bit, high in PLAY.
REQ-014 SHALL have port song_done, output, 1 bit, one-cycle end-of-song pulse.

Function
REQ-015 ROM entry SHALL be {dur[1:0], note[NOTE_W-1:0]}; entry length is (dur+1)*TICKS_PER_BEAT cycles.
REQ-016 Song 0 SHALL be notes 1,1,5,5,6,6,5 with durations 1,1,1,1,1,1,2 beats, followed by the end marker; notes 1..7 are do..ti.
REQ-017 FSM states SHALL be IDLE, PLAY and PAUSE.
REQ-018 Command priority SHALL be stop > start > pause.
REQ-019 IDLE + start SHALL latch song_select, set note_index=0 and enter PLAY; current_note shows entry 0 on the next cycle (1-cycle latency).
REQ-020 song_select SHALL be ignored except at a start taken from IDLE.
REQ-021 PLAY SHALL count tick_cnt 0..TICKS_PER_BEAT-1 and beat_cnt 0..dur; when both are at maximum, the sequencer advances to the next entry with counters cleared.
REQ-022 PLAY + pause SHALL enter PAUSE, freeze all counters and drive current_note to 0.
REQ-023 PAUSE + start SHALL resume PLAY with the counters unchanged; pause held in PAUSE SHALL have no effect.
REQ-024 start SHALL be ignored in PLAY; stop in any state SHALL enter IDLE, clear the counters and set current_note to 0.
REQ-025 End of song SHALL be the advance past index SONG_LEN-1 or reaching an end-marker entry; the marker is never output.
REQ-026 At end of song with loop_en=1, the sequencer SHALL set index 0, stay in PLAY and pulse song_done.
REQ-027 At end of song with loop_en=0, the sequencer SHALL enter IDLE, set current_note to 0 and pulse song_done.
REQ-028 An end marker at entry 0 SHALL return the sequencer to IDLE immediately with a song_done pulse.
REQ-029 If stop coincides with end of song, stop SHALL win and song_done SHALL NOT pulse.
REQ-030 song_done SHALL be high for exactly one cycle per song end.

Reset
REQ-031 rst SHALL asynchronously force IDLE, all counters to 0, current_note=0, note_index=0, playing=0, song_done=0 and the latched song to 0.
REQ-032 rst asserted during PLAY or PAUSE SHALL take effect immediately; after release the sequencer waits in IDLE for start.

Configuration
REQ-033 With macro NOTE_SEQ_GAP_EN defined, current_note SHALL be 0 during the last GAP_TICKS cycles of every entry (articulation gap); GAP_TICKS must be below TICKS_PER_BEAT.
REQ-034 Without NOTE_SEQ_GAP_EN, current_note SHALL hold the note for the full entry length, and no gap logic or GAP_TICKS use exists.

Verification (TICKS_PER_BEAT=4, SONG_LEN=8, macro off unless stated)
REQ-035 Select 0 + start pulse -> current_note=1 for 4 cycles, 1 for 4, 5, 5, 6, 6 for 4 each, then 5 for 8; then song_done for 1 cycle, playing=0 and current_note=0.
REQ-036 Pause at cycle 6, start at cycle 20 -> current_note=0 while paused, then note 1 (index 1) resumes for the remaining 2 cycles.
REQ-037 loop_en=1 -> after 32 cycles, song_done pulses, note_index=0, current_note=1 and playing stays 1.
REQ-038 stop and start together in PLAY -> IDLE, current_note=0, no song_done pulse.
REQ-039 rst asserted mid-note between clock edges -> outputs go to 0 before the next edge, and the sequencer stays in IDLE after release.
REQ-040 NOTE_SEQ_GAP_EN defined, GAP_TICKS=1 -> each 4-cycle note reads 3 cycles of the note then 1 cycle of 0.

Source files
------------

// File: rtl/note_sequencer.sv
// note_sequencer: plays songs from an internal ROM as a stream of note codes.
// Each ROM entry is {dur[1:0], note[NOTE_W-1:0]} and lasts (dur+1) beats.
// A note code of 0 is a rest. An all-ones note code is the end-of-song marker.
// Optional feature: define NOTE_SEQ_GAP_EN to silence the last GAP_TICKS
// cycles of every entry as an articulation gap.
module note_sequencer #(
    parameter int unsigned NOTE_W         = 4,
    parameter int unsigned SONG_CNT       = 4,
    parameter int unsigned SONG_LEN       = 32,
    parameter int unsigned TICKS_PER_BEAT = 25_000_000,
    parameter int unsigned GAP_TICKS      = 2_000_000
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [((SONG_CNT > 1) ? $clog2(SONG_CNT) : 1)-1:0] song_select,
    input  logic                                              start,
    input  logic                                              pause,
    input  logic                                              stop,
    input  logic                                              loop_en,
    output logic [NOTE_W-1:0]                                 current_note,
    output logic [((SONG_LEN > 1) ? $clog2(SONG_LEN) : 1)-1:0] note_index,
    output logic                                              playing,
    output logic                                              song_done
);

    localparam int unsigned SEL_W  = (SONG_CNT > 1) ? $clog2(SONG_CNT) : 1;
    localparam int unsigned IDX_W  = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
    localparam int unsigned TICK_W = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;

    localparam logic [NOTE_W-1:0] END_MARK = '1;
    // ORing this into an entry forces the duration bits, so a compare checks the note field only
    localparam logic [NOTE_W+1:0] DUR_MASK = {2'b11, {NOTE_W{1'b0}}};
    localparam logic [NOTE_W+1:0] MARK_ENT = {2'b11, END_MARK};
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICKS_PER_BEAT - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(SONG_LEN - 1);
`ifdef NOTE_SEQ_GAP_EN
    localparam logic [TICK_W-1:0] GAP_START = TICK_W'(TICKS_PER_BEAT - GAP_TICKS);
`endif

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StPause
    } state_t;

    // Song ROM; any entry not listed reads as an end marker
    function automatic logic [NOTE_W+1:0] rom_entry(input logic [SEL_W-1:0] song,
                                                    input logic [IDX_W-1:0] idx);
        logic [NOTE_W-1:0] n;
        logic [1:0]        d;
        n = '1;
        d = 2'd0;
        case (int'(song))
            0: begin
                case (int'(idx))
                    0, 1:    n = NOTE_W'(1);
                    2, 3:    n = NOTE_W'(5);
                    4, 5:    n = NOTE_W'(6);
                    6:       begin n = NOTE_W'(5); d = 2'd1; end
                    default: ;
                endcase
            end
            1: begin
                // ascending scale do..ti, one beat each
                if (int'(idx) < 7) n = NOTE_W'(int'(idx) + 1);
            end
            3: begin
                // fills every slot, so it ends by running off the last index
                case (int'(idx))
                    0:       n = NOTE_W'(2);
                    1:       begin n = NOTE_W'(3); d = 2'd1; end
                    2:       n = NOTE_W'(4);
                    3:       begin n = NOTE_W'(5); d = 2'd2; end
                    4:       n = NOTE_W'(6);
                    5:       n = NOTE_W'(7);
                    6:       begin n = NOTE_W'(1); d = 2'd3; end
                    7:       n = NOTE_W'(2);
                    default: ;
                endcase
            end
            default: ;  // song 2 and above: marker at entry 0
        endcase
        return {d, n};
    endfunction

    state_t             r_state, w_state_nx;
    logic [SEL_W-1:0]   r_song, w_song_nx;
    logic [IDX_W-1:0]   r_idx, w_idx_nx;
    logic [TICK_W-1:0]  r_tick, w_tick_nx;
    logic [1:0]         r_beat, w_beat_nx;
    logic               r_done, w_done_nx;

    logic [NOTE_W+1:0]  w_cur_entry;
    logic [NOTE_W+1:0]  w_next_entry;
    logic [NOTE_W+1:0]  w_first_entry;
    logic [NOTE_W-1:0]  w_cur_note;
    logic [1:0]         w_cur_dur;
    logic               w_entry_end;
    logic               w_song_end;
    logic               w_first_mark;
    logic               w_gap;

    assign w_cur_entry   = rom_entry(r_song, r_idx);
    assign w_next_entry  = rom_entry(r_song, r_idx + 1'b1);
    assign w_first_entry = rom_entry(song_select, '0);
    assign w_cur_note    = w_cur_entry[NOTE_W-1:0];
    assign w_cur_dur     = w_cur_entry[NOTE_W+1:NOTE_W];
    assign w_entry_end   = (r_tick == TICK_MAX) && (r_beat == w_cur_dur);
    // Look ahead so the marker entry is never entered and never shown
    assign w_song_end    = (r_idx == IDX_MAX) || ((w_next_entry | DUR_MASK) == MARK_ENT);
    assign w_first_mark  = ((w_first_entry | DUR_MASK) == MARK_ENT);

`ifdef NOTE_SEQ_GAP_EN
    assign w_gap = (r_beat == w_cur_dur) && (r_tick >= GAP_START);
`else
    assign w_gap = 1'b0;
`endif

    // Next-state: command decode (stop > start > pause), beat counting and song advance
    always_comb begin
        w_state_nx = r_state;
        w_song_nx  = r_song;
        w_idx_nx   = r_idx;
        w_tick_nx  = r_tick;
        w_beat_nx  = r_beat;
        w_done_nx  = 1'b0;
        if (stop) begin
            w_state_nx = StIdle;
            w_idx_nx   = '0;
            w_tick_nx  = '0;
            w_beat_nx  = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        w_song_nx = song_select;
                        w_idx_nx  = '0;
                        w_tick_nx = '0;
                        w_beat_nx = '0;
                        if (w_first_mark) begin
                            w_done_nx = 1'b1;
                        end else begin
                            w_state_nx = StPlay;
                        end
                    end
                end
                StPlay: begin
                    if (w_entry_end) begin
                        w_tick_nx = '0;
                        w_beat_nx = '0;
                        if (w_song_end) begin
                            w_done_nx = 1'b1;
                            w_idx_nx  = '0;
                            if (!loop_en) w_state_nx = StIdle;
                        end else begin
                            w_idx_nx = r_idx + 1'b1;
                        end
                    end else if (r_tick == TICK_MAX) begin
                        w_tick_nx = '0;
                        w_beat_nx = r_beat + 2'd1;
                    end else begin
                        w_tick_nx = r_tick + 1'b1;
                    end
                    // the cycle that samples pause still counts as played
                    if (pause && (w_state_nx == StPlay)) w_state_nx = StPause;
                end
                StPause: begin
                    if (start) w_state_nx = StPlay;
                end
                default: w_state_nx = StIdle;
            endcase
        end
    end

    // State and counter registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_song  <= '0;
            r_idx   <= '0;
            r_tick  <= '0;
            r_beat  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_song  <= w_song_nx;
            r_idx   <= w_idx_nx;
            r_tick  <= w_tick_nx;
            r_beat  <= w_beat_nx;
            r_done  <= w_done_nx;
        end
    end

    // Outputs decode straight from state so reset silences them without waiting for an edge
    always_comb begin
        playing      = (r_state == StPlay);
        current_note = '0;
        if (playing && !w_gap) current_note = w_cur_note;
        note_index   = r_idx;
        song_done    = r_done;
    end

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed and random stimulus for note_sequencer, checked every cycle
// against a model that tracks elapsed cycles within each song entry.
// Build with NOTE_SEQ_GAP_EN defined to exercise the articulation gap.
module tb_note_sequencer;

    localparam int TPB      = 4;
    localparam int SLEN     = 8;
    localparam int GAP      = 1;
    localparam int MARK     = 15;
    localparam int M_IDLE   = 0;
    localparam int M_PLAY   = 1;
    localparam int M_PAUSE  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] song_select;
    logic       start, pause, stop, loop_en;
    logic [3:0] current_note;
    logic [2:0] note_index;
    logic       playing, song_done;

    int checks = 0;
    int errors = 0;

    // Song contents: note codes and entry lengths in beats
    int note_tab [4][8] = '{'{1, 1, 5, 5, 6, 6, 5, 15},
                            '{1, 2, 3, 4, 5, 6, 7, 15},
                            '{15, 15, 15, 15, 15, 15, 15, 15},
                            '{2, 3, 4, 5, 6, 7, 1, 2}};
    int beat_tab [4][8] = '{'{1, 1, 1, 1, 1, 1, 2, 1},
                            '{1, 1, 1, 1, 1, 1, 1, 1},
                            '{1, 1, 1, 1, 1, 1, 1, 1},
                            '{1, 2, 1, 3, 1, 1, 4, 1}};

    int m_state, m_song, m_idx, m_el;
    bit m_done;

    note_sequencer #(
        .NOTE_W(4),
        .SONG_CNT(4),
        .SONG_LEN(SLEN),
        .TICKS_PER_BEAT(TPB),
        .GAP_TICKS(GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .song_select(song_select),
        .start(start),
        .pause(pause),
        .stop(stop),
        .loop_en(loop_en),
        .current_note(current_note),
        .note_index(note_index),
        .playing(playing),
        .song_done(song_done)
    );

    always #5 clk = ~clk;

    function automatic bit is_end(int s, int i);
        if (i >= SLEN) return 1'b1;
        return note_tab[s][i] == MARK;
    endfunction

    function automatic int entry_len(int s, int i);
        return beat_tab[s][i] * TPB;
    endfunction

    function automatic int exp_note();
        if (m_state != M_PLAY) return 0;
`ifdef NOTE_SEQ_GAP_EN
        if (m_el >= entry_len(m_song, m_idx) - GAP) return 0;
`endif
        return note_tab[m_song][m_idx];
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_song  = 0;
        m_idx   = 0;
        m_el    = 0;
        m_done  = 1'b0;
    endtask

    task automatic model_edge(input bit s, input bit p, input bit t, input bit l, input int sel);
        m_done = 1'b0;
        if (t) begin
            m_state = M_IDLE;
            m_idx   = 0;
            m_el    = 0;
        end else if (m_state == M_IDLE) begin
            if (s) begin
                m_song = sel;
                m_idx  = 0;
                m_el   = 0;
                if (is_end(m_song, 0)) m_done = 1'b1;
                else m_state = M_PLAY;
            end
        end else if (m_state == M_PLAY) begin
            m_el++;
            if (m_el == entry_len(m_song, m_idx)) begin
                m_el = 0;
                if (is_end(m_song, m_idx + 1)) begin
                    m_done = 1'b1;
                    m_idx  = 0;
                    if (!l) m_state = M_IDLE;
                end else begin
                    m_idx++;
                end
            end
            if (p && m_state == M_PLAY) m_state = M_PAUSE;
        end else if (s) begin
            m_state = M_PLAY;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string phase);
        chk({phase, ".note"},    {28'd0, current_note}, exp_note());
        chk({phase, ".index"},   {29'd0, note_index},   m_idx);
        chk({phase, ".playing"}, {31'd0, playing},      (m_state == M_PLAY) ? 1 : 0);
        chk({phase, ".done"},    {31'd0, song_done},    {31'd0, m_done});
    endtask

    // Apply one cycle of inputs, advance the model at the edge, compare just after it
    task automatic step(input string phase, input bit s, input bit p, input bit t,
                        input bit l, input int sel);
        start       = s;
        pause       = p;
        stop        = t;
        loop_en     = l;
        song_select = 2'(sel);
        @(posedge clk);
        model_edge(s, p, t, l, sel);
        #1;
        chk_all(phase);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        pause       = 1'b0;
        stop        = 1'b0;
        loop_en     = 1'b0;
        song_select = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        rst = 1'b0;

        // Song 0 played to the end without looping
        step("song0", 1, 0, 0, 0, 0);
        repeat (40) step("song0", 0, 0, 0, 0, 0);

        // Pause after cycle 6 (held for a while), resume at cycle 20
        step("pause", 1, 0, 0, 0, 0);
        repeat (5) step("pause", 0, 0, 0, 0, 0);
        step("pause", 0, 1, 0, 0, 0);
        repeat (13) step("pause", 0, 1, 0, 0, 0);
        step("resume", 1, 0, 0, 0, 0);
        repeat (35) step("resume", 0, 0, 0, 0, 0);

        // Looping playback, then stop
        step("loop", 1, 0, 0, 1, 0);
        repeat (70) step("loop", 0, 0, 0, 1, 0);
        step("loop_stop", 0, 0, 1, 1, 0);

        // Stop and start together while playing
        step("stopstart", 1, 0, 0, 0, 0);
        repeat (10) step("stopstart", 0, 0, 0, 0, 0);
        step("stopstart", 1, 0, 1, 0, 0);
        repeat (3) step("stopstart", 0, 0, 0, 0, 0);

        // End marker at entry 0
        step("marker0", 1, 0, 0, 0, 2);
        repeat (2) step("marker0", 0, 0, 0, 0, 0);

        // Full-length song ends past the last index; select changes mid-song are ignored
        step("fulllen", 1, 0, 0, 0, 3);
        repeat (60) step("fulllen", 0, 0, 0, 0, $urandom_range(3));

        // Stop on the same edge as the end of song 1
        step("stopend", 1, 0, 0, 0, 1);
        repeat (27) step("stopend", 0, 0, 0, 0, 1);
        step("stopend", 0, 0, 1, 0, 1);
        repeat (2) step("stopend", 0, 0, 0, 0, 1);

        // Asynchronous reset between clock edges
        step("arst", 1, 0, 0, 0, 0);
        repeat (6) step("arst", 0, 0, 0, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk_all("arst.async");
        @(posedge clk);
        #1;
        chk_all("arst.held");
        rst = 1'b0;
        repeat (4) step("arst.after", 0, 0, 0, 0, 0);

        // Random commands
        for (int i = 0; i < 800; i++) begin
            step("random",
                 $urandom_range(99) < 12,
                 $urandom_range(99) < 6,
                 $urandom_range(99) < 2,
                 $urandom_range(99) < 50,
                 $urandom_range(3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
